spis_shifter: RTL
=================

Name: spis_shifter

Overview:
- SPI slave end of the team's SPI link; receives frames driven by the SPI master clock generator and its data shifter.
- Oversamples SCLK, SS_n and MOSI in the system clock domain.
- Deserialises MOSI into DATA_SIZE-bit words and serialises a preloaded word onto MISO.
- Supports CPOL/CPHA modes 0-3 and reports framing errors and receive overruns to the local register interface.

Parameters:
- DATA_SIZE, 16, bits per frame; must match the master's DATA_SIZE.
- SYNC_STAGES, 2, flops in each input synchroniser; minimum 2.

Ports:
- i_sys_clk  in  1  system clock.
- i_sys_rst  in  1  reset, asynchronous, active-high.
- i_sclk  in  1  SPI clock from master, asynchronous.
- i_ss_n  in  1  slave select, active low, asynchronous.
- i_mosi  in  1  serial data from master.
- o_miso  out  1  serial data to master.
- i_cpol  in  1  clock idle level; static while i_ss_n is low.
- i_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; static while i_ss_n is low.
- i_tx_data  in  DATA_SIZE  word for the next frame.
- i_tx_load  in  1  captures i_tx_data when o_tx_ready=1.
- o_tx_ready  out  1  transmit buffer empty.
- o_rx_data  out  DATA_SIZE  last complete received word.
- o_rx_valid  out  1  o_rx_data unread; held until acknowledged.
- i_rx_ack  in  1  clears o_rx_valid.
- o_overrun  out  1  one-cycle pulse.
- o_frame_err  out  1  one-cycle pulse.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - Outputs: o_miso=0, o_tx_ready=1, o_rx_data=0, o_rx_valid=0, o_overrun=0, o_frame_err=0, o_busy=0.
  - Internal: synchronisers sclk=0, ss_n=1, mosi=0; bit counter=0; state=IDLE.
- Synchronisation and edge detection:
  - i_sclk, i_ss_n and i_mosi each pass through a SYNC_STAGES flop chain.
  - One further register on synced SCLK provides edge detection.
- Edge decoding:
  - Leading edge: rising if i_cpol=0, falling if i_cpol=1.
  - Sample edge: leading if i_cpha=0, trailing if i_cpha=1.
  - Shift edge: the other edge.
- Timing requirement: SCLK high and low phases are each at least SYNC_STAGES+2 sys clocks, i.e. master i_clk_period >= 8 at default.
- Latency: a raw sample edge at cycle N updates the rx shift register at N+SYNC_STAGES+1.
- FSM states: IDLE, ACTIVE, COMPLETE.
  - IDLE -> ACTIVE on synced ss_n falling.
    - Bit counter cleared.
    - tx shift register <= tx buffer if full, else all zeros.
    - Buffer marked empty.
  - ACTIVE, on each sample edge: shift synced MOSI into rx shift register (MSB first); bit counter +1.
  - ACTIVE, on each shift edge with bit counter > 0: shift tx register so the next bit reaches o_miso.
    - The first shift edge in CPHA=1 therefore leaves the MSB in place.
  - ACTIVE -> COMPLETE when the bit counter reaches DATA_SIZE.
    - Same cycle: o_rx_data <= assembled word; o_rx_valid <= 1.
    - If o_rx_valid was already 1 and i_rx_ack=0: o_overrun pulses 1 cycle; the new word overwrites the old.
  - ACTIVE -> IDLE on synced ss_n rising:
    - With 0 < count < DATA_SIZE: o_frame_err pulses 1 cycle; partial word discarded; o_rx_data unchanged.
    - With count=0: silent, no pulse.
  - COMPLETE: all SCLK edges ignored; -> IDLE on synced ss_n rising.
  - An ss_n rise on the same cycle as the final sample edge completes the word (COMPLETE path wins); no frame error.
- o_miso = tx shift register MSB in ACTIVE and COMPLETE, 0 in IDLE.
- Transmit buffer:
  - i_tx_load with o_tx_ready=1 captures i_tx_data; o_tx_ready -> 0 the next cycle.
  - Load while o_tx_ready=0 is ignored.
  - Load on the frame-start cycle with an empty buffer fills the buffer for the following frame.
- Receive acknowledge:
  - i_rx_ack clears o_rx_valid next cycle.
  - Ack coinciding with word completion: o_rx_valid stays 1, no overrun.
- Reset mid-frame: returns to reset values immediately; no error pulse.

Optional Feature:
- SPIS_LSB_FIRST_EN defined: rx and tx shift LSB first; o_rx_data bit 0 holds the first received bit; o_miso presents tx bit 0 first.
- Undefined: MSB first in both directions.

Test Plan:
1. Mode 0, i_clk_period=10, tx preload 0xA5C3, master sends 0x1234 -> o_rx_data=0x1234, o_rx_valid=1; MISO bits captured by bench = 0xA5C3; o_tx_ready=1 after SS fall.
2. Modes 1, 2, 3 with master 0xBEEF, tx 0x0F0F -> both words correct in every mode; no o_frame_err.
3. Two frames 0x0001 and 0x0002, no i_rx_ack -> one o_overrun pulse at the second completion; o_rx_data=0x0002; o_rx_valid stays 1.
4. SS_n deasserted after 7 SCLK periods -> one o_frame_err pulse; o_rx_data keeps previous 0x0002; state returns to IDLE; next full frame of 0x5555 received correctly.
5. No tx preload -> MISO all zeros for the frame; i_tx_load 0x00FF on the frame-start cycle -> transmitted in the next frame.
6. i_sys_rst asserted after 5 bits -> all outputs at reset values within 1 cycle; next frame of 0xFFFF received correctly.

Source files
------------

// File: rtl/spis_shifter.sv
//------------------------------------------------------------------------------
// Module   : spis_shifter
// Brief    : SPI slave shifter. SCLK/SS_n/MOSI are oversampled in the system
//            clock domain. Supports CPOL/CPHA modes 0-3 with framing-error and
//            overrun reporting. Define SPIS_LSB_FIRST_EN for LSB-first shifting.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spis_shifter #(
  parameter int DATA_SIZE   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  input  logic                 i_sclk,
  input  logic                 i_ss_n,
  input  logic                 i_mosi,
  output logic                 o_miso,
  input  logic                 i_cpol,
  input  logic                 i_cpha,
  input  logic [DATA_SIZE-1:0] i_tx_data,
  input  logic                 i_tx_load,
  output logic                 o_tx_ready,
  output logic [DATA_SIZE-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ack,
  output logic                 o_overrun,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int                 c_CNT_W    = $clog2(DATA_SIZE + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_SIZE - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_n_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_ss_n_d;

  logic w_sclk_s;
  logic w_ss_n_s;
  logic w_mosi_s;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_lead_edge;
  logic w_trail_edge;
  logic w_sample_edge;
  logic w_shift_edge;
  logic w_ss_fall;
  logic w_ss_rise;

  logic w_start;
  logic w_sample_en;
  logic w_shift_en;
  logic w_complete;
  logic w_frame_err;

  logic [c_CNT_W-1:0]   r_bit_cnt;
  // Only DATA_SIZE-1 bits are held; the final bit is merged straight into w_rx_next.
  logic [DATA_SIZE-2:0] r_rx_shift;
  logic [DATA_SIZE-1:0] w_rx_next;
  logic [DATA_SIZE-1:0] r_tx_shift;
  logic [DATA_SIZE-1:0] w_tx_shifted;
  logic                 w_tx_bit;
  logic [DATA_SIZE-1:0] r_tx_buf;
  logic                 r_tx_full;
  logic [DATA_SIZE-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_overrun;
  logic                 r_frame_err;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_sclk_sync <= '0;
      r_ss_n_sync <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_n_d    <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_ss_n_sync <= {r_ss_n_sync[SYNC_STAGES-2:0], i_ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_d    <= w_sclk_s;
      r_ss_n_d    <= w_ss_n_s;
    end
  end

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_n_s = r_ss_n_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  assign w_sclk_rise   = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall   = ~w_sclk_s & r_sclk_d;
  assign w_lead_edge   = i_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail_edge  = i_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample_edge = i_cpha ? w_trail_edge : w_lead_edge;
  assign w_shift_edge  = i_cpha ? w_lead_edge : w_trail_edge;
  assign w_ss_fall     = r_ss_n_d & ~w_ss_n_s;
  assign w_ss_rise     = ~r_ss_n_d & w_ss_n_s;

`ifdef SPIS_LSB_FIRST_EN
  assign w_rx_next    = {w_mosi_s, r_rx_shift};
  assign w_tx_shifted = {1'b0, r_tx_shift[DATA_SIZE-1:1]};
  assign w_tx_bit     = r_tx_shift[0];
`else
  assign w_rx_next    = {r_rx_shift, w_mosi_s};
  assign w_tx_shifted = {r_tx_shift[DATA_SIZE-2:0], 1'b0};
  assign w_tx_bit     = r_tx_shift[DATA_SIZE-1];
`endif

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_sample_en  = 1'b0;
    w_shift_en   = 1'b0;
    w_complete   = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_fall) begin
          w_state_next = ST_ACTIVE;
          w_start      = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_sample_edge) begin
          w_sample_en = 1'b1;
          if (r_bit_cnt == c_LAST_BIT) begin
            w_complete = 1'b1;
          end
        end
        if (w_shift_edge && (r_bit_cnt != '0)) begin
          w_shift_en = 1'b1;
        end
        // A final sample coinciding with SS_n rising still completes the word.
        if (w_complete) begin
          w_state_next = w_ss_rise ? ST_IDLE : ST_COMPLETE;
        end else if (w_ss_rise) begin
          w_state_next = ST_IDLE;
          w_frame_err  = (r_bit_cnt != '0);
        end
      end
      ST_COMPLETE: begin
        if (w_ss_rise) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
    end else begin
      if (w_start) begin
        r_bit_cnt  <= '0;
        r_rx_shift <= '0;
        r_tx_shift <= r_tx_full ? r_tx_buf : '0;
      end else begin
        if (w_sample_en) begin
          r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
`ifdef SPIS_LSB_FIRST_EN
          r_rx_shift <= w_rx_next[DATA_SIZE-1:1];
`else
          r_rx_shift <= w_rx_next[DATA_SIZE-2:0];
`endif
        end
        if (w_shift_en) begin
          r_tx_shift <= w_tx_shifted;
        end
      end
    end
  end

  // Frame start empties the buffer; a load in that same cycle refills it for the next frame.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_tx_buf  <= '0;
      r_tx_full <= 1'b0;
    end else begin
      if (w_start) begin
        r_tx_full <= 1'b0;
      end
      if (i_tx_load && !r_tx_full) begin
        r_tx_buf  <= i_tx_data;
        r_tx_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= 1'b0;
      r_frame_err <= w_frame_err;
      if (w_complete) begin
        r_rx_data  <= w_rx_next;
        r_rx_valid <= 1'b1;
        r_overrun  <= r_rx_valid & ~i_rx_ack;
      end else if (i_rx_ack) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign o_miso      = (r_state != ST_IDLE) & w_tx_bit;
  assign o_tx_ready  = ~r_tx_full;
  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_overrun   = r_overrun;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
